// File: rtl/gen_clk_rate_monitor.sv
// gen_clk_rate_monitor: counts rising edges of a generated clock per fixed window of source clocks and tracks lock.
//   clk_i          source clock (only clock)
//   rst_i          synchronous active-high reset
//   gen_in_i       generated clock, sampled as asynchronous data
//   enable_i       measurement enable
//   clear_err_i    clears sticky err_o
//   edge_count_o   rising-edge count of the last completed window
//   count_valid_o  one-cycle pulse when edge_count_o updates
//   locked_o       generated clock is in tolerance
//   err_o          sticky loss-of-lock flag
module gen_clk_rate_monitor #(
    parameter int WINDOW    = 64,
    parameter int CNT_W     = 8,
    parameter int EXP_EDGES = 16,
    parameter int TOL       = 1,
    parameter int LOCK_CNT  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             gen_in_i,
    input  logic             enable_i,
    input  logic             clear_err_i,
    output logic [CNT_W-1:0] edge_count_o,
    output logic             count_valid_o,
    output logic             locked_o,
    output logic             err_o
);
    localparam int WW = $clog2(WINDOW);
    localparam int GW = $clog2(LOCK_CNT + 1);
    // Bounds are deliberately confined to CNT_W+1 signed bits so a small EXP_EDGES cannot underflow.
    localparam logic signed [CNT_W:0] LO = (CNT_W + 1)'(EXP_EDGES - TOL);
    localparam logic signed [CNT_W:0] HI = (CNT_W + 1)'(EXP_EDGES + TOL);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [GW-1:0]     good_q, good_d;
    logic [CNT_W-1:0]  edge_count_q, edge_count_d;
    logic              count_valid_q, count_valid_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;

    logic              rise, active, term, in_tol;
    logic [CNT_W-1:0]  total;
    logic [GW-1:0]     good_inc;
    logic signed [CNT_W:0] tot_s;

    assign rise     = s2_q & ~s3_q;
    assign active   = (state_q != IDLE) & enable_i;
    assign term     = active & (wcnt_q == WW'(WINDOW - 1));
    // Saturating add of this cycle's rise: the accumulator never wraps.
    assign total    = (rise && acc_q != '1) ? acc_q + CNT_W'(1'b1) : acc_q;
    assign tot_s    = $signed({1'b0, total});
    assign in_tol   = (tot_s >= LO) && (tot_s <= HI);
    assign good_inc = good_q + GW'(1'b1);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = enable_i ? ACQUIRE : IDLE;
            ACQUIRE: state_d = !enable_i ? IDLE : (term && in_tol && good_inc == GW'(LOCK_CNT)) ? LOCKED : ACQUIRE;
            LOCKED:  state_d = !enable_i ? IDLE : (term && !in_tol) ? ACQUIRE : LOCKED;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wcnt_d        = (!active || term) ? '0 : wcnt_q + WW'(1'b1);
        acc_d         = (!active || term) ? '0 : total;
        good_d        = !active ? '0 : !term ? good_q : !in_tol ? '0 : (state_q == ACQUIRE) ? good_inc : good_q;
        edge_count_d  = term ? total : edge_count_q;
        count_valid_d = term;
        locked_d      = state_d == LOCKED;
        // A loss of lock in the same cycle as clear_err_i keeps the flag set.
        err_d         = (term && state_q == LOCKED && !in_tol) | (err_q & ~clear_err_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            wcnt_q        <= '0;
            acc_q         <= '0;
            good_q        <= '0;
            edge_count_q  <= '0;
            count_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            s1_q          <= gen_in_i;
            s2_q          <= s1_q;
            s3_q          <= s2_q;
            wcnt_q        <= wcnt_d;
            acc_q         <= acc_d;
            good_q        <= good_d;
            edge_count_q  <= edge_count_d;
            count_valid_q <= count_valid_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
        end
    end

    assign edge_count_o  = edge_count_q;
    assign count_valid_o = count_valid_q;
    assign locked_o      = locked_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_gen_clk_rate_monitor.sv
// tb_gen_clk_rate_monitor: scoreboard bench for gen_clk_rate_monitor.
module tb_gen_clk_rate_monitor;
    typedef struct packed {logic [7:0] c; logic l; logic e;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1, gen = 1'b0, en = 1'b0, en2 = 1'b0, clr = 1'b0;
    logic [7:0] ec;
    logic [3:0] ec2;
    logic cv, lk, er, cv2, lk2, er2;
    logic [63:0] pat = '0, next_pat = '0;
    logic [5:0] idx = '0;
    int checks = 0, errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    localparam logic [63:0] P_DIV2 = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] P_DIV4 = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] P_DIV8 = 64'hF0F0_F0F0_F0F0_F0F0;

    always #5 clk = ~clk;

    gen_clk_rate_monitor dut (
        .clk_i(clk), .rst_i(rst), .gen_in_i(gen), .enable_i(en), .clear_err_i(clr),
        .edge_count_o(ec), .count_valid_o(cv), .locked_o(lk), .err_o(er)
    );

    gen_clk_rate_monitor #(.CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst), .gen_in_i(gen), .enable_i(en2), .clear_err_i(clr),
        .edge_count_o(ec2), .count_valid_o(cv2), .locked_o(lk2), .err_o(er2)
    );

    // 64-periodic pattern generator; a new pattern takes effect only at index 0 so windows stay pure.
    initial forever begin
        @(posedge clk);
        #1;
        if (idx == 6'd0) pat = next_pat;
        gen = pat[idx];
        idx = idx + 6'd1;
    end

    // Scoreboard: every count_valid pulse pops one expected {count, locked, err}.
    initial forever begin
        @(posedge clk);
        #2;
        if (cv === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pulse got count=%0d locked=%0d err=%0d, no pulse expected", ec, lk, er);
            end else begin
                mon_e = sb.pop_front();
                if ({ec, lk, er} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_report got count=%0d locked=%0d err=%0d exp count=%0d locked=%0d err=%0d",
                             ec, lk, er, mon_e.c, mon_e.l, mon_e.e);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic exp_t mk(int c, bit l, bit x);
        exp_t r;
        r.c = 8'(c);
        r.l = l;
        r.e = x;
        return r;
    endfunction

    function automatic logic [63:0] pat_n(int n);
        logic [63:0] r = '0;
        for (int k = 0; k < n; k++) r[2*k+1] = 1'b1;
        return r;
    endfunction

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cv !== 1'b1 && n < 200);
        if (cv !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL pulse_timeout waited %0d cycles, count_valid required", n);
        end
    endtask

    // Aligns the generator so window starts fall 3 cycles after pattern index 0, then enables.
    task automatic start_enable();
        idx = 6'd0;
        repeat (3) @(negedge clk);
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ec !== 8'd0) begin errors++; $display("FAIL reset_edge_count got %0d exp 0", ec); end
        checks++; if (cv !== 1'b0) begin errors++; $display("FAIL reset_count_valid got %0d exp 0", cv); end
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL reset_locked got %0d exp 0", lk); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL reset_err got %0d exp 0", er); end
        checks++; if ({ec2, cv2, lk2, er2} !== 7'd0) begin errors++; $display("FAIL reset_sat_outputs got %b exp 0", {ec2, cv2, lk2, er2}); end
        rst = 1'b0;
        repeat (80) @(negedge clk);
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL idle_locked got %0d exp 0", lk); end
    endtask

    task automatic test_basic_lock();
        int n;
        pat = P_DIV4;
        next_pat = P_DIV4;
        sb.push_back(mk(16, 0, 0));
        start_enable();
        wait_pulse(n);
        checks++; if (n != 65) begin errors++; $display("FAIL first_report_latency got %0d exp 65", n); end
        sb.push_back(mk(16, 1, 0));
        wait_pulse(n);
        checks++; if (n != 64) begin errors++; $display("FAIL report_period got %0d exp 64", n); end
        @(negedge clk);
        checks++; if (cv !== 1'b0) begin errors++; $display("FAIL pulse_width got %0d exp 0", cv); end
    endtask

    task automatic test_loss_of_lock();
        int n;
        next_pat = P_DIV8;
        sb.push_back(mk(16, 1, 0));
        wait_pulse(n);
        sb.push_back(mk(8, 0, 1));
        wait_pulse(n);
        next_pat = P_DIV4;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL clear_err got %0d exp 0", er); end
        sb.push_back(mk(8, 0, 0));
        sb.push_back(mk(16, 0, 0));
        sb.push_back(mk(16, 1, 0));
        repeat (3) wait_pulse(n);
        next_pat = P_DIV8;
        sb.push_back(mk(16, 1, 0));
        wait_pulse(n);
        sb.push_back(mk(8, 0, 1));
        repeat (63) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (cv !== 1'b1 || er !== 1'b1) begin errors++; $display("FAIL set_beats_clear got valid=%0d err=%0d exp valid=1 err=1", cv, er); end
        @(negedge clk);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_sticky got %0d exp 1", er); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL clear_err_again got %0d exp 0", er); end
    endtask

    task automatic test_tolerance();
        int n;
        sb.push_back(mk(8, 0, 0));
        wait_pulse(n);
        next_pat = pat_n(15);
        sb.push_back(mk(8, 0, 0));
        wait_pulse(n);
        next_pat = pat_n(17);
        sb.push_back(mk(15, 0, 0));
        wait_pulse(n);
        next_pat = pat_n(14);
        sb.push_back(mk(17, 1, 0));
        wait_pulse(n);
        next_pat = '0;
        sb.push_back(mk(14, 0, 1));
        wait_pulse(n);
        sb.push_back(mk(0, 0, 1));
        sb.push_back(mk(0, 0, 1));
        repeat (2) wait_pulse(n);
        en = 1'b0;
        @(negedge clk);
        checks++; if (lk !== 1'b0 || ec !== 8'd0) begin errors++; $display("FAIL const_gen got locked=%0d count=%0d exp 0 0", lk, ec); end
    endtask

    task automatic test_saturation();
        int n;
        pat = P_DIV2;
        next_pat = P_DIV2;
        en2 = 1'b1;
        for (int w = 0; w < 3; w++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (cv2 !== 1'b1 && n < 200);
            checks++; if (cv2 !== 1'b1 || ec2 !== 4'd15) begin errors++; $display("FAIL sat_count w%0d got valid=%0d count=%0d exp 1 15", w, cv2, ec2); end
            checks++; if (lk2 !== 1'b0) begin errors++; $display("FAIL sat_locked w%0d got %0d exp 0", w, lk2); end
            if (w == 0) begin
                checks++; if (n != 65) begin errors++; $display("FAIL sat_latency got %0d exp 65", n); end
            end
        end
        en2 = 1'b0;
    endtask

    task automatic test_enable_drop();
        int n;
        bit seen;
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_held_idle got %0d exp 1", er); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        pat = P_DIV4;
        next_pat = P_DIV4;
        sb.push_back(mk(16, 0, 0));
        sb.push_back(mk(16, 1, 0));
        start_enable();
        repeat (2) wait_pulse(n);
        repeat (30) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++; if (lk !== 1'b0) begin errors++; $display("FAIL drop_locked got %0d exp 0", lk); end
        checks++; if (ec !== 8'd16) begin errors++; $display("FAIL drop_edge_count got %0d exp 16", ec); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL drop_err got %0d exp 0", er); end
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (cv === 1'b1) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL drop_no_pulse got pulse exp none"); end
        sb.push_back(mk(16, 0, 0));
        start_enable();
        wait_pulse(n);
        checks++; if (n != 65) begin errors++; $display("FAIL reenable_latency got %0d exp 65", n); end
    endtask

    task automatic test_reset_mid();
        int n;
        sb.push_back(mk(16, 1, 0));
        wait_pulse(n);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({ec, cv, lk, er} !== 11'd0) begin errors++; $display("FAIL midreset_outputs got count=%0d valid=%0d locked=%0d err=%0d exp all 0", ec, cv, lk, er); end
        rst = 1'b0;
        sb.push_back(mk(16, 0, 0));
        sb.push_back(mk(16, 1, 0));
        wait_pulse(n);
        checks++; if (n != 65) begin errors++; $display("FAIL reacquire_latency got %0d exp 65", n); end
        wait_pulse(n);
        @(negedge clk);
        checks++; if (lk !== 1'b1) begin errors++; $display("FAIL reacquire_locked got %0d exp 1", lk); end
    endtask

    initial begin
        test_reset();
        test_basic_lock();
        test_loss_of_lock();
        test_tolerance();
        test_saturation();
        test_enable_drop();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gen_clk_rate_monitor.md
# gen_clk_rate_monitor

Measures a generated clock by sampling it as data in the source clock domain. It counts rising edges of the generated clock over a fixed window of source-clock cycles and reports each count. It declares lock after enough consecutive in-tolerance windows, and flags loss of lock. It sits downstream of a clock manager / divider output and checks the ratio promised by the generated-clock constraint.

## Interface
- `WINDOW`, 64: source-clock cycles per measurement window; must be ≥ 4.
- `CNT_W`, 8: width of the edge accumulator and `edge_count`.
- `EXP_EDGES`, 16: expected rising edges per window.
- `TOL`, 1: allowed absolute deviation from `EXP_EDGES`.
- `LOCK_CNT`, 2: consecutive in-tolerance windows required to assert lock.

Ports:
- `clk` in 1: source clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `gen_in` in 1: generated clock, treated as an asynchronous data input.
- `enable` in 1: measurement enable.
- `clear_err` in 1: clears sticky `err`.
- `edge_count` out CNT_W: edge count of the last completed window.
- `count_valid` out 1: one-cycle pulse when `edge_count` updates.
- `locked` out 1: generated clock is in tolerance.
- `err` out 1: sticky loss-of-lock flag.

## Operation
- **Synchronizer:** `gen_in` passes through a 2-flop synchronizer (s1, s2) plus a history flop s3. `rise = s2 & ~s3`.
- **Counters:** the window counter `wcnt` counts 0..WINDOW-1. The accumulator `acc` counts `rise` cycles and saturates at 2^CNT_W-1; it never wraps.
- **Window terminal:** the cycle with `wcnt == WINDOW-1`.
  - Total = `acc` + `rise` in that cycle, saturated. Latch it into `edge_count`.
  - Pulse `count_valid`.
  - Restart `wcnt` at 0 and `acc` at 0. There are no gap cycles between windows.
- **In-tolerance test:** EXP_EDGES-TOL ≤ total ≤ EXP_EDGES+TOL. Compute with CNT_W+1-bit signed arithmetic, so EXP_EDGES < TOL does not underflow.
- **State machine (IDLE, ACQUIRE, LOCKED):**
  - IDLE: `wcnt`, `acc` and `good_cnt` held at 0; `locked`=0. If `enable`=1 → ACQUIRE; the first window starts in the next cycle.
  - ACQUIRE, at terminal:
    - In tolerance → `good_cnt`++. When it reaches `LOCK_CNT` → LOCKED, `locked`=1.
    - Out of tolerance → `good_cnt`=0.
  - LOCKED, at terminal: out of tolerance → ACQUIRE, `locked`=0, `err`=1, `good_cnt`=0. In tolerance → stay.
  - `enable`=0 in ACQUIRE or LOCKED → IDLE next cycle.
    - Partial window is discarded and no `count_valid` is issued.
    - `locked`=0.
    - `edge_count` holds its value; `err` holds; this does not set `err`.
- **Sticky error:** `clear_err` clears `err`. If set and clear occur in the same cycle, set wins.
- **Reset:** all flops go to 0. This includes s1–s3, `edge_count`=0, `count_valid`=0, `locked`=0, `err`=0; state = IDLE. Reset mid-window discards the window.

## Timing
- **All outputs registered.** `edge_count`, `count_valid`, `locked` and `err` change on the clock edge that ends the terminal cycle. They are visible in the following cycle.
- **Edge-count latency:** a `gen_in` edge captured by s1 at edge k affects `rise` during the cycle after edge k+1. That edge is counted in `acc` at edge k+2.
- **Report period:** after `enable` is first seen high at edge e, the first `count_valid` is visible in the cycle after edge e+1+WINDOW-1. After that, `count_valid` pulses every WINDOW cycles.
- **Earliest lock:** `locked` rises together with the `LOCK_CNT`-th `count_valid`.
- **Maximum countable rate:** `gen_in` at clk/2 (toggling every cycle) gives WINDOW/2 rises per window. Faster inputs alias; this is out of scope.

## Test plan
Parameters for all scenarios: WINDOW=64, EXP_EDGES=16, TOL=1, LOCK_CNT=2, CNT_W=8 unless noted.
1. **Basic lock:** `gen_in` = clk/4, `enable`=1 → `count_valid` every 64 cycles with `edge_count`=16. `locked`=1 on the 2nd pulse. `err`=0.
2. **Loss of lock:** after lock, switch `gen_in` to clk/8 → first full window after the switch reports 8. `locked`→0 and `err`→1 with that pulse. Pulse `clear_err` → `err`=0. Assert `clear_err` on the exact set cycle → `err` stays 1.
3. **Tolerance edges:** bench drives exactly 15, then 17 rises per window → lock after 2 windows. Then 14 → `locked`=0, `err`=1. Constant `gen_in` → `edge_count`=0, never locks.
4. **Saturation:** CNT_W=4, `gen_in` = clk/2 → `edge_count`=15 (32 rises saturated), no wrap, never locks.
5. **Enable drop:** drop `enable` at window cycle 30 → no `count_valid`, `locked`=0, `edge_count` holds 16. Re-enable → next report 64 cycles later, value 16.
6. **Reset mid-operation:** `rst` mid-window while locked → next cycle all outputs 0, state IDLE. With `enable` held high, lock reacquired after 2 windows.
